// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned BE_W        = 4;
  localparam int unsigned DMEM_ADDR_W = 11;

  // One word access as presented by a requester
  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bundles for the data-memory arbiter.
interface dmem_port_if;
  import riscv_pkg::*;

  logic            req;
  logic            we;
  logic [BE_W-1:0] be;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if #(
  parameter int unsigned ADDR_W = riscv_pkg::DMEM_ADDR_W
);
  import riscv_pkg::*;

  logic              en;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;

  modport master (output en, we, be, addr, wdata, input rdata);
  modport slave  (input en, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive contended cycles lost by ext; raises the
// force flag once ext has lost MAX_STALL cycles in a row.
module dmem_arb_starve_ctr #(
  parameter int unsigned MAX_STALL = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic both_req,
  input  logic ext_req,
  input  logic ext_gnt,
  output logic force_c
);

  localparam int unsigned CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Contended and not granted to ext means core won this cycle
  always_comb begin
    cnt_d = cnt_q;
    if (!ext_req || ext_gnt) begin
      cnt_d = '0;
    end else if (both_req && (cnt_q != CNT_W'(MAX_STALL))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_c = (cnt_q == CNT_W'(MAX_STALL));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port dmem: core has fixed priority, ext is
// protected by a starvation guard. Optional statistics under DMEM_ARB_STATS_EN.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMEM_ADDR_W,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  dmem_port_if.slave  core,
  dmem_port_if.slave  ext,
  dmem_mem_if.master  mem
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] conflict_cnt_o,
  output logic [31:0] forced_cnt_o
`endif
);

  logic       both_req;
  logic       force_ext;
  logic       any_gnt;
  arb_owner_e owner;
  dmem_req_t  core_pl;
  dmem_req_t  ext_pl;
  dmem_req_t  sel_pl;

  assign both_req = core.req & ext.req;

  // Core wins unless it is idle or ext has hit the stall limit
  always_comb begin
    owner = OWN_CORE;
    if (ext.req && (!core.req || force_ext)) begin
      owner = OWN_EXT;
    end
  end

  assign core.gnt = core.req & (owner == OWN_CORE);
  assign ext.gnt  = ext.req  & (owner == OWN_EXT);
  assign any_gnt  = core.gnt | ext.gnt;

  dmem_arb_starve_ctr #(
    .MAX_STALL (MAX_STALL)
  ) u_starve_ctr (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .both_req (both_req),
    .ext_req  (ext.req),
    .ext_gnt  (ext.gnt),
    .force_c  (force_ext)
  );

  assign core_pl = '{we: core.we, be: core.be, addr: core.addr, wdata: core.wdata};
  assign ext_pl  = '{we: ext.we,  be: ext.be,  addr: ext.addr,  wdata: ext.wdata};
  assign sel_pl  = (owner == OWN_EXT) ? ext_pl : core_pl;

  // Memory side; upper address bits wrap on the array size
  assign mem.en    = any_gnt;
  assign mem.we    = any_gnt & sel_pl.we;
  assign mem.be    = any_gnt ? sel_pl.be : '0;
  assign mem.addr  = sel_pl.addr[ADDR_W-1:0];
  assign mem.wdata = sel_pl.wdata;

  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_pl.addr[XLEN-1:ADDR_W];

  logic            core_pend_q;
  logic            ext_pend_q;
  logic [XLEN-1:0] core_rdata_q;
  logic [XLEN-1:0] ext_rdata_q;

  // Track which owner a load belongs to; hold last returned word per port
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      core_pend_q  <= 1'b0;
      ext_pend_q   <= 1'b0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      core_pend_q <= core.gnt & ~core.we;
      ext_pend_q  <= ext.gnt  & ~ext.we;
      if (core_pend_q) begin
        core_rdata_q <= mem.rdata;
      end
      if (ext_pend_q) begin
        ext_rdata_q <= mem.rdata;
      end
    end
  end

  assign core.rvalid = core_pend_q;
  assign ext.rvalid  = ext_pend_q;
  assign core.rdata  = core_pend_q ? mem.rdata : core_rdata_q;
  assign ext.rdata   = ext_pend_q  ? mem.rdata : ext_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  // Forced grant: ext wins while core is also requesting
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      conflict_cnt_o <= '0;
      forced_cnt_o   <= '0;
    end else begin
      if (both_req) begin
        conflict_cnt_o <= conflict_cnt_o + 32'd1;
      end
      if (ext.gnt && core.req) begin
        forced_cnt_o <= forced_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
